// File: rtl/vexriscv_dbus_decoder.sv
// ---------------------------------------------------------------------------
// vexriscv_dbus_decoder - VexRiscv dBus to N-slave address decoder, one access in flight. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vexriscv_dbus_decoder #(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {32'h00F0_0000, 32'h00E0_0000,
                                                        32'h00D0_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {4{32'hFFF0_0000}},
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       dBus_cmd_valid,
  output logic                       dBus_cmd_ready,
  input  logic                       dBus_cmd_payload_wr,
  input  logic [31:0]                dBus_cmd_payload_address,
  input  logic [31:0]                dBus_cmd_payload_data,
  input  logic [1:0]                 dBus_cmd_payload_size,
  output logic                       dBus_rsp_ready,
  output logic                       dBus_rsp_error,
  output logic [31:0]                dBus_rsp_data,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic                       s_we,
  output logic [3:0]                 s_be,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ack,
  output logic                       err_flag,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    err_flag_q, err_flag_d;
  logic [31:0]             err_addr_q, err_addr_d;

  logic [NUM_SLAVES-1:0]   hit_oh;
  logic [3:0]              cmd_be;
  logic [31:0]             rdata_sel;
  logic                    ack_sel;
  logic                    fail;

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    hit_oh = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (((dBus_cmd_payload_address ^ SLAVE_BASE[32*i +: 32]) & SLAVE_MASK[32*i +: 32]) == 32'd0) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    case (dBus_cmd_payload_size)
      2'd0:    cmd_be = 4'b0001 << dBus_cmd_payload_address[1:0];
      2'd1:    cmd_be = 4'b0011 << {dBus_cmd_payload_address[1], 1'b0};
      default: cmd_be = 4'b1111;
    endcase
  end

  always_comb begin
    rdata_sel = 32'd0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) rdata_sel = rdata_sel | s_rdata[32*i +: 32];
    end
  end

  assign ack_sel = |(s_ack & sel_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    err_flag_d = err_flag_q & ~err_clr;
    err_addr_d = err_addr_q;
    fail       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dBus_cmd_valid) begin
          state_d = S_BUSY;
          cnt_d   = 16'd0;
          sel_d   = hit_oh;
          we_d    = dBus_cmd_payload_wr;
          be_d    = cmd_be;
          addr_d  = dBus_cmd_payload_address;
          wdata_d = dBus_cmd_payload_data;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 16'd1;
        // An empty select means unmapped; an ack on the final cycle beats the timeout.
        if (sel_q == '0) begin
          fail = 1'b1;
        end else if (ack_sel) begin
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_RESP;
            rsp_data_d = rdata_sel;
            rsp_err_d  = 1'b0;
          end
        end else if (cnt_q == TMO_LAST) begin
          fail = 1'b1;
        end
        if (fail) begin
          err_flag_d = 1'b1;
          err_addr_d = addr_q;
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_RESP;
            rsp_data_d = 32'd0;
            rsp_err_d  = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
      err_flag_q <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign dBus_cmd_ready = (state_q == S_IDLE);
  assign dBus_rsp_ready = (state_q == S_RESP);
  assign dBus_rsp_error = (state_q == S_RESP) & rsp_err_q;
  assign dBus_rsp_data  = rsp_data_q;
  assign s_sel          = (state_q == S_BUSY) ? sel_q : '0;
  assign s_we           = we_q;
  assign s_be           = be_q;
  assign s_addr         = addr_q;
  assign s_wdata        = wdata_q;
  assign err_flag       = err_flag_q;
  assign err_addr       = err_addr_q;

endmodule

`default_nettype wire

// File: doc/vexriscv_dbus_decoder.md
VEXRISCV_DBUS_DECODER -- requirements
Module: vexriscv_dbus_decoder

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4: number of slave ports, range 1..8.
REQ-002 SHALL have parameter SLAVE_BASE, default {32'h00F0_0000,32'h00E0_0000,32'h00D0_0000,32'h0000_0000}: flat per-slave base address, slave i at bits [32i+31:32i].
REQ-003 SHALL have parameter SLAVE_MASK, default {4{32'hFFF0_0000}}: flat per-slave compare mask, same layout.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: BUSY cycles before abort, range 1..65535.
REQ-005 clk  in  1  core clock; the only clock.
REQ-006 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 dBus_cmd_valid  in  1  CPU command valid.
REQ-008 dBus_cmd_ready  out  1  command accepted.
REQ-009 dBus_cmd_payload_wr  in  1  1=write, 0=read.
REQ-010 dBus_cmd_payload_address  in  32  byte address.
REQ-011 dBus_cmd_payload_data  in  32  write data, already lane-replicated by CPU.
REQ-012 dBus_cmd_payload_size  in  2  0=byte, 1=half, 2=word.
REQ-013 dBus_rsp_ready  out  1  read response valid, one-cycle pulse.
REQ-014 dBus_rsp_error  out  1  read response error, qualified by dBus_rsp_ready.
REQ-015 dBus_rsp_data  out  32  read data.
REQ-016 s_sel  out  NUM_SLAVES  one-hot slave select.
REQ-017 s_we / s_be / s_addr / s_wdata  out  1/4/32/32  shared request fields.
REQ-018 s_rdata  in  32*NUM_SLAVES  flat slave read data.
REQ-019 s_ack  in  NUM_SLAVES  slave completion, one cycle.
REQ-020 err_flag / err_addr  out  1/32  sticky error flag and failing address.
REQ-021 err_clr  in  1  clears err_flag.

Function
REQ-022 SHALL implement states IDLE, BUSY, RESP; at most one outstanding transaction.
REQ-023 dBus_cmd_ready SHALL be 1 iff state==IDLE; a command fires on cmd_valid&cmd_ready, and its fields are registered on that edge.
REQ-024 Decode at fire: hit_i = ((addr ^ SLAVE_BASE_i) & SLAVE_MASK_i)==0; the lowest-index hit wins; no hit = unmapped.
REQ-025 s_be SHALL be size 0 -> 4'b0001<<addr[1:0], size 1 -> 4'b0011<<{addr[1],1'b0}, size 2/3 -> 4'b1111.
REQ-026 BUSY: s_sel one-hot held stable with the registered fields until ack or timeout; s_sel=0 outside BUSY.
REQ-027 In BUSY, s_ack of the selected slave SHALL be taken; acks from unselected slaves SHALL be ignored.
REQ-028 Read ack: s_rdata of the selected slave SHALL be latched; go RESP; RESP SHALL drive rsp_ready=1, rsp_error=0 for one cycle, then IDLE.
REQ-029 Write ack: go IDLE directly; no rsp_ready pulse.
REQ-030 The timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle; reaching TIMEOUT_CYCLES without an ack SHALL abort: s_sel drops the next cycle.
REQ-031 An ack in the same cycle as timeout SHALL win, giving normal completion.
REQ-032 Unmapped or aborted read SHALL go RESP with rsp_error=1 and rsp_data=32'h0000_0000; an unmapped read SHALL spend exactly one BUSY cycle with s_sel=0.
REQ-033 Unmapped or aborted access (read or write) SHALL set err_flag=1 and load err_addr with the address; a write SHALL return to IDLE.
REQ-034 err_clr SHALL clear err_flag, but a new error in the same cycle SHALL win; err_addr SHALL hold until the next error.
REQ-035 Read latency, fire to rsp_ready: ack-cycle offset + 2; minimum 2 cycles (ack in first BUSY cycle).

Reset
REQ-036 reset_n=0 SHALL asynchronously force state IDLE, the counter to 0, s_sel=0, rsp_ready=0, rsp_error=0, rsp_data=0, err_flag=0, err_addr=0, and all registered request fields to 0.
REQ-037 Reset mid-BUSY SHALL abort the transfer silently; after release, cmd_ready=1 in the first cycle.

Verification
REQ-038 Read word 0x00F0_0010, slave 3 acks in first BUSY cycle with 0xCAFEF00D -> s_sel=4'b1000, s_be=4'hF, rsp_ready 2 cycles after fire, rsp_data 0xCAFEF00D, rsp_error=0.
REQ-039 Byte write 0x00E0_0003 -> s_sel=4'b0100, s_we=1, s_be=4'b1000; ack -> no rsp_ready; cmd_ready=1 the next cycle.
REQ-040 Read 0x1230_0000 (unmapped) -> s_sel stays 0, rsp_ready with rsp_error=1 and data 0, err_flag=1, err_addr=0x1230_0000.
REQ-041 TIMEOUT_CYCLES=4, read slave 0, no ack -> abort after 4 BUSY cycles, rsp_error=1; repeat with ack in the 4th BUSY cycle -> normal data.
REQ-042 err_clr pulsed in the same cycle as an unmapped-write error -> err_flag stays 1; a later lone err_clr -> 0.
REQ-043 reset_n low during BUSY -> s_sel=0 immediately; no rsp_ready; cmd_ready=1 in the first cycle after release.
